// File: rtl/alu_if.sv
// rtl/alu_if.sv - start/done handshake and result bundle for alu_multicycle
//
// Purpose: groups the operand, opcode and handshake signals with the registered
// result and flags, so that both sides connect through one port.
// Ports (signals):
//   start, cu_aluOp[3:0], data1, data2, shamt   requester -> ALU
//   busy, done, aluOut, zero, negative,
//   carry, overflow, div_zero                   ALU -> requester
// Modports: master (requester side), slave (ALU side).
interface alu_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [3:0]       cu_aluOp;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] aluOut;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             div_zero;

  modport master (
    output start, cu_aluOp, data1, data2, shamt,
    input  busy, done, aluOut, zero, negative, carry, overflow, div_zero
  );

  modport slave (
    input  start, cu_aluOp, data1, data2, shamt,
    output busy, done, aluOut, zero, negative, carry, overflow, div_zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered ALU with iterative multiply/divide/remainder
//
// Purpose: accepts an opcode and operands on start (when not busy), completes
// logic/add/sub/shift/compare ops in one cycle and multiply/divide/remainder
// over WIDTH cycles with a shift-add multiplier and a restoring divider.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_if.slave: start, cu_aluOp, data1, data2, shamt in;
//          busy, done, aluOut, zero, negative, carry, overflow, div_zero out
// Configuration macro: ALU_MULDIV_EN compiles in the MUL/DIV states and the
// iterative datapath; without it opcodes 1100-1110 return 0 in one cycle.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);
  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_INC  = 4'b0011;
  localparam logic [3:0] OP_DEC  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1111;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;
`endif

  logic             busy;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] sc_b;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_ovf, sc_dz;
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic             wr_carry, wr_ovf, wr_dz;

  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d, negative_q, negative_d;
  logic             carry_q, carry_d, overflow_q, overflow_d;
  logic             div_zero_q, div_zero_d, done_q, done_d;

  // Single-cycle datapath; inc/dec reuse the add/sub path with a constant 1.
  always_comb begin
    sc_b     = (bus.cu_aluOp == OP_INC || bus.cu_aluOp == OP_DEC) ?
               {{(WIDTH-1){1'b0}}, 1'b1} : bus.data2;
    add_w    = {1'b0, bus.data1} + {1'b0, sc_b};
    sub_w    = {1'b0, bus.data1} - {1'b0, sc_b};
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    case (bus.cu_aluOp)
      OP_PASS: sc_res = bus.data1;
      OP_ADD, OP_INC: begin
        sc_res   = add_w[WIDTH-1:0];
        sc_carry = add_w[WIDTH];
        sc_ovf   = (bus.data1[WIDTH-1] == sc_b[WIDTH-1]) &&
                   (add_w[WIDTH-1] != bus.data1[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        sc_res   = sub_w[WIDTH-1:0];
        sc_carry = sub_w[WIDTH];  // borrow out of the WIDTH+1 bit subtract
        sc_ovf   = (bus.data1[WIDTH-1] != sc_b[WIDTH-1]) &&
                   (sub_w[WIDTH-1] != bus.data1[WIDTH-1]);
      end
      OP_AND:  sc_res = bus.data1 & bus.data2;
      OP_OR:   sc_res = bus.data1 | bus.data2;
      OP_XOR:  sc_res = bus.data1 ^ bus.data2;
      OP_NOT:  sc_res = ~bus.data1;
      OP_SHL:  sc_res = bus.data1 << bus.shamt;
      OP_SHR:  sc_res = bus.data1 >> bus.shamt;
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.data1 < bus.data2)};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.data1) < $signed(bus.data2))};
`ifdef ALU_MULDIV_EN
      // Only committed when data2 is zero; otherwise the DIV state takes over.
      OP_DIVU: begin sc_res = '1;        sc_dz = 1'b1; end
      OP_REMU: begin sc_res = bus.data1; sc_dz = 1'b1; end
`endif
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam int SHW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  // acc: product accumulator / partial remainder
  // opa: shifted multiplicand / dividend shifting into quotient
  // opb: shifted multiplier   / divisor
  logic [WIDTH-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0] st_acc, st_a, st_b;
  logic [WIDTH-1:0] mul_acc, mul_a, mul_b, div_rem, div_q;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;

  assign busy = (state_q != IDLE);

  // One iteration step. Iteration 0 runs on the accepting edge straight from
  // the operand inputs, so the last one lands WIDTH-1 edges later.
  always_comb begin
    st_acc   = busy ? acc_q : '0;
    st_a     = busy ? opa_q : bus.data1;
    st_b     = busy ? opb_q : bus.data2;
    mul_acc  = st_acc + (st_b[0] ? st_a : '0);
    mul_a    = st_a << 1;
    mul_b    = st_b >> 1;
    div_sh   = {st_acc, st_a[WIDTH-1]};
    div_diff = div_sh - {1'b0, st_b};
    div_ge   = ~div_diff[WIDTH];
    div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    div_q    = {st_a[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    wr_en    = 1'b0;
    wr_val   = sc_res;
    wr_carry = sc_carry;
    wr_ovf   = sc_ovf;
    wr_dz    = sc_dz;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d = bus.cu_aluOp;
          if (bus.cu_aluOp == OP_MUL) begin
            state_d = MUL;
            cnt_d   = SHW'(1);
            acc_d   = mul_acc;
            opa_d   = mul_a;
            opb_d   = mul_b;
          end else if ((bus.cu_aluOp == OP_DIVU || bus.cu_aluOp == OP_REMU) &&
                       (bus.data2 != '0)) begin
            state_d = DIV;
            cnt_d   = SHW'(1);
            acc_d   = div_rem;
            opa_d   = div_q;
            opb_d   = bus.data2;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        acc_d = (state_q == MUL) ? mul_acc : div_rem;
        opa_d = (state_q == MUL) ? mul_a : div_q;
        opb_d = (state_q == MUL) ? mul_b : opb_q;
        if (cnt_q == CNT_LAST) begin
          wr_en    = 1'b1;
          wr_val   = (state_q == MUL)  ? mul_acc :
                     (op_q == OP_DIVU) ? div_q : div_rem;
          wr_carry = 1'b0;
          wr_ovf   = 1'b0;
          wr_dz    = 1'b0;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    wr_en    = bus.start;
    wr_val   = sc_res;
    wr_carry = sc_carry;
    wr_ovf   = sc_ovf;
    wr_dz    = sc_dz;
  end
`endif

  // Flags are derived from the value being written, on the same edge.
  always_comb begin
    alu_out_d  = wr_en ? wr_val : alu_out_q;
    zero_d     = wr_en ? (wr_val == '0) : zero_q;
    negative_d = wr_en ? wr_val[WIDTH-1] : negative_q;
    carry_d    = wr_en ? wr_carry : carry_q;
    overflow_d = wr_en ? wr_ovf : overflow_q;
    div_zero_d = wr_en ? wr_dz : div_zero_q;
    done_d     = wr_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q  <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      alu_out_q  <= alu_out_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.aluOut   = alu_out_q;
  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.div_zero = div_zero_q;
endmodule
